rf_scoreboard: RTL and testbench



---
 rtl/rf_scoreboard.sv | 121 ++++++++++++
 tb/tb_rf_scoreboard.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: parametrised register file with same-cycle write-to-read
// bypass, per-register busy scoreboard and a post-reset clearing sweep.
// Optional build macro: RF_ZERO_REG_EN (register 0 hardwired to zero).
module rf_scoreboard #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              reg_write,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              ready
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic              run;
  logic              clr_en;
  logic              wr_en;
  logic              al_en;
  logic              rs_hit;
  logic              rt_hit;

  // An address is usable if it maps onto a real register (and, with the
  // zero register enabled, is not register 0).
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
`ifdef RF_ZERO_REG_EN
    return (32'(a) < DEPTH) && (a != '0);
`else
    return 32'(a) < DEPTH;
`endif
  endfunction

  // State and sweep counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, sweep control and write/alloc qualification.
  // Outputs are gated by rst so they read as idle while reset is held,
  // even before the reset edge has moved the FSM back to INIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    run     = 1'b0;
    wr_en   = 1'b0;
    al_en   = 1'b0;
    case (state_q)
      ST_INIT: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        run   = ~rst;
        wr_en = run & reg_write & addr_ok(rd_addr);
        al_en = run & alloc_valid & addr_ok(alloc_addr);
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Register array: sweep clears one entry per edge, then writeback port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_en)     mem_q[cnt_q]   <= '0;
      else if (wr_en) mem_q[rd_addr] <= rd_data;
    end
  end

  // Busy scoreboard: writeback clears, allocation sets; allocation wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      if (wr_en) busy_q[rd_addr]    <= 1'b0;
      if (al_en) busy_q[alloc_addr] <= 1'b1;
    end
  end

  // Combinational read ports with bypass from the writeback port.
  always_comb begin
    rs_hit  = wr_en & (rd_addr == rs_addr);
    rt_hit  = wr_en & (rd_addr == rt_addr);
    rs_data = '0;
    rt_data = '0;
    rs_busy = 1'b0;
    rt_busy = 1'b0;
    ready   = run;
    if (run && addr_ok(rs_addr)) begin
      rs_data = rs_hit ? rd_data : mem_q[rs_addr];
      rs_busy = busy_q[rs_addr] & ~rs_hit;
    end
    if (run && addr_ok(rt_addr)) begin
      rt_data = rt_hit ? rd_data : mem_q[rt_addr];
      rt_busy = busy_q[rt_addr] & ~rt_hit;
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Testbench for rf_scoreboard: two instances (DEPTH=32 and DEPTH=20) share
// stimulus; a behavioural model checks every cycle, plus a directed table.
module tb_rf_scoreboard;

`ifdef RF_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  localparam logic [31:0] ZV = ZR ? 32'h0 : 32'hFFFF_FFFF;
  localparam logic        ZB = ~ZR;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, rd_addr, alloc_addr;
  logic [31:0] rd_data;
  logic        reg_write, alloc_valid;
  logic [31:0] rs_data [2];
  logic [31:0] rt_data [2];
  logic        rs_busy [2];
  logic        rt_busy [2];
  logic        ready   [2];

  int nchk = 0;
  int nerr = 0;

  // Reference model state, one set per instance.
  logic [31:0] m_mem  [2][32];
  bit          m_busy [2][32];
  int          m_cnt  [2];
  bit          m_run  [2];

  always #5 clk = ~clk;

  rf_scoreboard #(.DATA_W(32), .DEPTH(32), .ADDR_W(5)) dut32 (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data[0]), .rt_data(rt_data[0]), .rs_busy(rs_busy[0]),
    .rt_busy(rt_busy[0]), .rd_addr(rd_addr), .rd_data(rd_data),
    .reg_write(reg_write), .alloc_valid(alloc_valid),
    .alloc_addr(alloc_addr), .ready(ready[0]));

  rf_scoreboard #(.DATA_W(32), .DEPTH(20), .ADDR_W(5)) dut20 (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data[1]), .rt_data(rt_data[1]), .rs_busy(rs_busy[1]),
    .rt_busy(rt_busy[1]), .rd_addr(rd_addr), .rd_data(rd_data),
    .reg_write(reg_write), .alloc_valid(alloc_valid),
    .alloc_addr(alloc_addr), .ready(ready[1]));

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] wd;
    logic        we, al;
    logic [4:0]  aa;
    logic [31:0] ers, ert;
    logic        ebs, ebt;
  } vec_t;

  vec_t tbl [11];

  function automatic int depth_of(int d);
    return (d == 0) ? 32 : 20;
  endfunction

  function automatic bit m_ok(int d, logic [4:0] a);
    return (int'(a) < depth_of(d)) && !(ZR && a == 5'd0);
  endfunction

  function automatic logic [31:0] exp_data(int d, logic [4:0] a);
    if (rst || !m_run[d] || !m_ok(d, a)) return 32'h0;
    if (reg_write && rd_addr == a) return rd_data;
    return m_mem[d][a];
  endfunction

  function automatic logic exp_busy(int d, logic [4:0] a);
    if (rst || !m_run[d] || !m_ok(d, a)) return 1'b0;
    return m_busy[d][a] && !(reg_write && rd_addr == a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_cnt[d] = 0;
        m_run[d] = 1'b0;
        for (int i = 0; i < 32; i++) m_busy[d][i] = 1'b0;
      end else if (!m_run[d]) begin
        m_mem[d][m_cnt[d]] = 32'h0;
        m_cnt[d]++;
        if (m_cnt[d] == depth_of(d)) m_run[d] = 1'b1;
      end else begin
        if (reg_write && m_ok(d, rd_addr)) begin
          m_mem[d][rd_addr]  = rd_data;
          m_busy[d][rd_addr] = 1'b0;
        end
        if (alloc_valid && m_ok(d, alloc_addr)) m_busy[d][alloc_addr] = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("ready[%0d]", d), {31'b0, ready[d]}, {31'b0, m_run[d] && !rst});
      chk($sformatf("rs_data[%0d]", d), rs_data[d], exp_data(d, rs_addr));
      chk($sformatf("rt_data[%0d]", d), rt_data[d], exp_data(d, rt_addr));
      chk($sformatf("rs_busy[%0d]", d), {31'b0, rs_busy[d]}, {31'b0, exp_busy(d, rs_addr)});
      chk($sformatf("rt_busy[%0d]", d), {31'b0, rt_busy[d]}, {31'b0, exp_busy(d, rt_addr)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_model();
    tick();
  endtask

  task automatic idle();
    reg_write = 1'b0; alloc_valid = 1'b0;
    rd_addr = 5'd0; rd_data = 32'h0; alloc_addr = 5'd0;
  endtask

  initial begin
    tbl[0]  = '{5'd5, 5'd6, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    tbl[1]  = '{5'd5, 5'd6, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    tbl[2]  = '{5'd5, 5'd7, 5'd0, 32'h0, 1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    tbl[3]  = '{5'd7, 5'd7, 5'd7, 32'h12, 1'b1, 1'b0, 5'd0, 32'h12, 32'h12, 1'b0, 1'b0};
    tbl[4]  = '{5'd7, 5'd7, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h12, 32'h12, 1'b0, 1'b0};
    tbl[5]  = '{5'd7, 5'd5, 5'd7, 32'h34, 1'b1, 1'b1, 5'd7, 32'h34, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[6]  = '{5'd7, 5'd7, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h34, 32'h34, 1'b1, 1'b1};
    tbl[7]  = '{5'd0, 5'd7, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 5'd0, ZV, 32'h34, 1'b0, 1'b1};
    tbl[8]  = '{5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, ZV, ZV, ZB, ZB};
    tbl[9]  = '{5'd3, 5'd7, 5'd7, 32'h56, 1'b1, 1'b0, 5'd0, 32'h0, 32'h56, 1'b0, 1'b0};
    tbl[10] = '{5'd7, 5'd31, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h56, 32'h0, 1'b0, 1'b0};

    // Reset held for two edges.
    rst = 1'b1; rs_addr = 5'd0; rt_addr = 5'd0; idle();
    tick();
    cycle();
    rst = 1'b0;

    // Sweep: ready rises after exactly DEPTH edges; writes ignored meanwhile.
    reg_write = 1'b1; rd_addr = 5'd4; rd_data = 32'hAAAA5555;
    alloc_valid = 1'b1; alloc_addr = 5'd4; rs_addr = 5'd4; rt_addr = 5'd9;
    for (int k = 0; k < 34; k++) begin
      if (k == 20) idle();
      @(negedge clk);
      check_model();
      chk("sweep_ready32", {31'b0, ready[0]}, {31'b0, k >= 32});
      chk("sweep_ready20", {31'b0, ready[1]}, {31'b0, k >= 20});
      tick();
    end
    idle();

    // Every register reads zero after the sweep.
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i);
      @(negedge clk);
      check_model();
      chk("post_sweep_rs", rs_data[0], 32'h0);
      chk("post_sweep_rt", rt_data[0], 32'h0);
      tick();
    end

    // Directed table on the DEPTH=32 instance.
    for (int i = 0; i < 11; i++) begin
      rs_addr = tbl[i].rs; rt_addr = tbl[i].rt; rd_addr = tbl[i].rd;
      rd_data = tbl[i].wd; reg_write = tbl[i].we;
      alloc_valid = tbl[i].al; alloc_addr = tbl[i].aa;
      @(negedge clk);
      check_model();
      chk($sformatf("tbl%0d_rs_data", i), rs_data[0], tbl[i].ers);
      chk($sformatf("tbl%0d_rt_data", i), rt_data[0], tbl[i].ert);
      chk($sformatf("tbl%0d_rs_busy", i), {31'b0, rs_busy[0]}, {31'b0, tbl[i].ebs});
      chk($sformatf("tbl%0d_rt_busy", i), {31'b0, rt_busy[0]}, {31'b0, tbl[i].ebt});
      tick();
    end
    idle();

    // Out-of-range address 25 on the DEPTH=20 instance.
    reg_write = 1'b1; rd_addr = 5'd25; rd_data = 32'h55;
    alloc_valid = 1'b1; alloc_addr = 5'd25; rs_addr = 5'd25; rt_addr = 5'd19;
    @(negedge clk);
    check_model();
    chk("oor_bypass20", rs_data[1], 32'h0);
    chk("oor_bypass32", rs_data[0], 32'h55);
    tick();
    idle();
    @(negedge clk);
    check_model();
    chk("oor_read20", rs_data[1], 32'h0);
    chk("oor_busy20", {31'b0, rs_busy[1]}, 32'h0);
    chk("oor_read32", rs_data[0], 32'h55);
    chk("oor_busy32", {31'b0, rs_busy[0]}, 32'h1);
    tick();

    // Mid-operation reset: fill R1..R3, allocate R2, pulse rst for one edge.
    for (int i = 1; i <= 3; i++) begin
      reg_write = 1'b1; rd_addr = 5'(i); rd_data = 32'h100 + 32'(i);
      cycle();
    end
    idle();
    alloc_valid = 1'b1; alloc_addr = 5'd2;
    cycle();
    idle();
    rs_addr = 5'd2; rt_addr = 5'd3;
    @(negedge clk);
    check_model();
    chk("pre_rst_busy", {31'b0, rs_busy[0]}, 32'h1);
    chk("pre_rst_rt", rt_data[0], 32'h103);
    tick();
    rst = 1'b1; reg_write = 1'b1; rd_addr = 5'd3; rd_data = 32'hBAD;
    @(negedge clk);
    check_model();
    chk("rst_ready", {31'b0, ready[0]}, 32'h0);
    tick();
    rst = 1'b0; idle();
    @(negedge clk);
    check_model();
    chk("rst_busy", {31'b0, rs_busy[0]}, 32'h0);
    chk("rst_ready_init", {31'b0, ready[0]}, 32'h0);
    tick();
    for (int k = 1; k < 32; k++) cycle();
    for (int i = 1; i <= 3; i++) begin
      rs_addr = 5'(i);
      @(negedge clk);
      check_model();
      chk("rst_cleared", rs_data[0], 32'h0);
      chk("rst_ready_back", {31'b0, ready[0]}, 32'h1);
      tick();
    end

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 800; n++) begin
      rst         = ($urandom_range(0, 149) == 0);
      rs_addr     = 5'($urandom_range(0, 31));
      rt_addr     = 5'($urandom_range(0, 31));
      rd_addr     = ($urandom_range(0, 3) == 0) ? rs_addr : 5'($urandom_range(0, 31));
      rd_data     = $urandom;
      reg_write   = ($urandom_range(0, 1) == 1);
      alloc_valid = ($urandom_range(0, 4) < 2);
      alloc_addr  = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
